// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//   Sequencer and HI/LO result holder for the bit-serial divider.
//   A one-cycle start latches the operands. The block then holds the divider
//   operate strobe for DIV_CYCLES+1 cycles, captures the quotient into LO and
//   the remainder into HI, and pulses done. mthi/mtlo writes are accepted
//   only while idle.
//
//   Optional feature: define DIVSEQ_ZERO_TRAP_EN to abort a divide-by-zero
//   one cycle after acceptance. The abort pulses done and div0_exc together
//   and leaves HI/LO untouched.
// ---------------------------------------------------------------------------
module div_sequencer #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_lo_in,
  input  logic [31:0] div_hi_in,
  input  logic        div_by0_in
);

  // One spare bit so the counter never wraps before the terminal compare.
  localparam int CW = $clog2(DIV_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            accept_s;
  logic            capture_s;
  logic            trap_s;

  logic            busy_r;
  logic            done_r;
  logic            div0_exc_r;
  logic            div_op_r;
  logic [31:0]     hi_r;
  logic [31:0]     lo_r;
  logic [31:0]     dividend_r;
  logic [31:0]     divisor_r;

`ifndef DIVSEQ_ZERO_TRAP_EN
  // The divider's zero flag has no consumer unless trapping is enabled.
  logic            unused_div_by0_s;
  assign unused_div_by0_s = div_by0_in;
`endif

  // Next-state and control decode for the IDLE/RUN/CAPT sequence.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    trap_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          cnt_s    = CNT_ZERO;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
`ifdef DIVSEQ_ZERO_TRAP_EN
        // The zero flag is valid from the first RUN cycle onward. Checking it
        // only there keeps the abort at a fixed one-cycle latency.
        if ((cnt_r == CNT_ZERO) && div_by0_in) begin
          state_s = IDLE;
          trap_s  = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          state_s = CAPT;
          cnt_s   = cnt_r + CNT_ONE;
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r + CNT_ONE;
        end
`else
        if (cnt_r == CNT_LAST) begin
          state_s = CAPT;
          cnt_s   = cnt_r + CNT_ONE;
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r + CNT_ONE;
        end
`endif
      end
      CAPT: begin
        // The divider holds its final results while div_op stays high, so
        // capture on the edge that leaves CAPT.
        state_s   = IDLE;
        capture_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and iteration counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered status and strobe outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r     <= 1'b0;
      div_op_r   <= 1'b0;
      done_r     <= 1'b0;
      div0_exc_r <= 1'b0;
    end else begin
      busy_r     <= (state_s != IDLE);
      // Dropping div_op in IDLE re-arms the divider for the next operation.
      div_op_r   <= (state_s != IDLE);
      done_r     <= capture_s | trap_s;
      div0_exc_r <= trap_s;
    end
  end

  // Operand latch: loaded only on acceptance and held until the next one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dividend_r <= 32'd0;
      divisor_r  <= 32'd0;
    end else if (accept_s) begin
      dividend_r <= op_a;
      divisor_r  <= op_b;
    end else begin
      dividend_r <= dividend_r;
      divisor_r  <= divisor_r;
    end
  end

  // Architectural HI/LO: the divider capture, or an mthi/mtlo write while idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (capture_s) begin
      hi_r <= div_hi_in;
      lo_r <= div_lo_in;
    end else if (state_r == IDLE) begin
      // A write on the accepting edge still lands; the later capture wins.
      if (wr_hi) begin
        hi_r <= wr_data;
      end else begin
        hi_r <= hi_r;
      end
      if (wr_lo) begin
        lo_r <= wr_data;
      end else begin
        lo_r <= lo_r;
      end
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign div0_exc     = div0_exc_r;
  assign div_op       = div_op_r;
  assign hi           = hi_r;
  assign lo           = lo_r;
  assign div_dividend = dividend_r;
  assign div_divisor  = divisor_r;

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
//   Directed bench for div_sequencer. The bench contains a restoring
//   bit-serial divider model that steps once per cycle while div_op is high.
//   Each issued operation pushes its hand-computed expected result onto a
//   queue. A monitor pops one entry per done pulse and compares the result,
//   the latency and the div_op high time against that entry.
// ---------------------------------------------------------------------------
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div0_exc;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_lo_in;
  logic [31:0] div_hi_in;
  logic        div_by0_in;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int opcnt   = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exc;
    int          lat;
    int          ops;
    int          t_acc;
  } exp_t;

  exp_t sb[$];

  div_sequencer #(.DIV_CYCLES(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .wr_hi        (wr_hi),
    .wr_lo        (wr_lo),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .div0_exc     (div0_exc),
    .hi           (hi),
    .lo           (lo),
    .div_op       (div_op),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_lo_in    (div_lo_in),
    .div_hi_in    (div_hi_in),
    .div_by0_in   (div_by0_in)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Restoring divider model. The index resets to 31 while div_op is low.
  // The model performs one step per cycle and holds its results once the
  // index drops below 0.
  int          m_idx;
  logic [31:0] m_q;
  logic [31:0] m_r;
  logic [32:0] m_t;
  assign m_t = {m_r, div_dividend[m_idx[4:0]]};

  always @(posedge clk) begin
    if (!div_op) begin
      m_idx <= 31;
      m_q   <= 32'd0;
      m_r   <= 32'd0;
    end else if (m_idx >= 0) begin
      if (m_t >= {1'b0, div_divisor}) begin
        m_r        <= 32'(m_t - {1'b0, div_divisor});
        m_q[m_idx] <= 1'b1;
      end else begin
        m_r <= m_t[31:0];
      end
      m_idx <= m_idx - 1;
    end
  end

  assign div_lo_in  = (div_divisor == 32'd0) ? 32'd0 : m_q;
  assign div_hi_in  = (div_divisor == 32'd0) ? 32'd0 : m_r;
  assign div_by0_in = div_op & (div_divisor == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: consumes one scoreboard entry per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (div_op) opcnt++;
      if (div0_exc && !done) chk("exc_without_done", 32'(div0_exc), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("res_lo", lo, e.lo);
          chk("res_hi", hi, e.hi);
          chk("res_exc", 32'(div0_exc), 32'(e.exc));
          chk("latency", 32'(cyc - e.t_acc), 32'(e.lat));
          chk("div_op_cycles", 32'(opcnt), 32'(e.ops));
        end
        opcnt = 0;
      end else if (!busy) begin
        opcnt = 0;
      end
    end
  end

  // Issue one start and optionally push its expected result.
  // On return the simulation sits at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic eexc, input int lat, input int ops,
                       input logic push, input logic wh, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.lo = elo; e.hi = ehi; e.exc = eexc; e.lat = lat; e.ops = ops;
      e.t_acc = cyc + 1;
      sb.push_back(e);
    end
    start = 1'b1; op_a = a; op_b = b; wr_hi = wh; wr_data = wd;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    op_a = 32'h5555_5555; op_b = 32'hAAAA_AAAA;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_exc"}, 32'(div0_exc), 32'd0);
    chk({tag, "_div_op"}, 32'(div_op), 32'd0);
    chk({tag, "_hi"}, hi, 32'd0);
    chk({tag, "_lo"}, lo, 32'd0);
    chk({tag, "_dividend"}, div_dividend, 32'd0);
    chk({tag, "_divisor"}, div_divisor, 32'd0);
  endtask

  initial begin
    logic [31:0] prior_hi;
    logic [31:0] prior_lo;
    reset_n = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // 100 / 7 -> q 14, r 2
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 33, 1'b1, 1'b0, 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("div_op_after_accept", 32'(div_op), 32'd1);
    chk("latched_dividend", div_dividend, 32'd100);
    chk("latched_divisor", div_divisor, 32'd7);
    wait_idle();

    // 0xFFFFFFFF / 0x10000 -> q 0xFFFF, r 0xFFFF
    issue(32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF,
          1'b0, 33, 33, 1'b1, 1'b0, 32'd0);
    wait_idle();

    // 5 / 0
`ifdef DIVSEQ_ZERO_TRAP_EN
    issue(32'd5, 32'd0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1, 1, 1'b1, 1'b0, 32'd0);
    prior_hi = 32'h0000_FFFF;
`else
    issue(32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 33, 33, 1'b1, 1'b0, 32'd0);
    prior_hi = 32'd0;
`endif
    wait_idle();

    // A second start and an mthi pulse mid-RUN are both ignored.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 33, 1'b1, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    start = 1'b1; op_a = 32'd1000; op_b = 32'd3; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    chk("hi_write_ignored_busy", hi, prior_hi);
    chk("dividend_held", div_dividend, 32'd100);
    chk("divisor_held", div_divisor, 32'd7);
    wait_idle();

    // mtlo in IDLE
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo_idle", lo, 32'h1234_5678);
    chk("hi_untouched_by_mtlo", hi, 32'd2);

    // start + mthi on the same edge: HI first takes wr_data, then the remainder.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 33, 1'b1, 1'b1, 32'hCAFE_F00D);
    chk("mthi_on_accept", hi, 32'hCAFE_F00D);
    chk("lo_before_capture", lo, 32'h1234_5678);
    wait_idle();

    // Simultaneous mthi/mtlo
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0A0B_0C0D;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("both_write_hi", hi, 32'h0A0B_0C0D);
    chk("both_write_lo", lo, 32'h0A0B_0C0D);
    prior_hi = hi;
    prior_lo = lo;

    // Reset during cycle 10 of RUN: no done, then a fresh operation works.
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    chk("pre_reset_hi_hold", hi, prior_hi);
    chk("pre_reset_lo_hold", lo, prior_lo);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_all_zero("midrun_reset");
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", 32'(done), 32'd0);
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 33, 1'b1, 1'b0, 32'd0);
    wait_idle();

    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
